// File: rtl/seven_segment_decoder.sv
// Loopback checker: recovers a 0-99 score from two active-low
// 7-segment buses after they hold a stable pattern.
module seven_segment_decoder #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic       i_Clk,
   input  logic       i_Reset,
   input  logic [6:0] i_Segment1,
   input  logic [6:0] i_Segment2,
   output logic [6:0] o_Score,
   output logic       o_Score_Valid,
   output logic       o_Score_Update,
   output logic       o_Error,
   output logic [7:0] o_Error_Count
);

   typedef enum logic [1:0] {
      SETTLE,
      COMPARE,
      COMMIT,
      HOLD
   } state_t;

   localparam logic [7:0] LP_MAX  = 8'(STABLE_CYCLES);
   localparam logic [7:0] LP_LAST = 8'(STABLE_CYCLES - 1);

   state_t      r_State;
   state_t      w_Next;
   logic [13:0] r_Sample;
   logic [7:0]  r_Count;
   logic [13:0] r_Committed;
   logic        r_Has_Commit;
   logic [6:0]  r_Score;
   logic        r_Valid;
   logic        r_Update;
   logic        r_Error;
   logic [7:0]  r_Err_Cnt;

   logic [13:0] w_Input;
   logic        w_Same;
   logic        w_Go;
   logic        w_Tens_Ok;
   logic        w_Ones_Ok;
   logic [3:0]  w_Tens;
   logic [3:0]  w_Ones;
   logic [6:0]  w_Score;

   // Segment pattern to {legal, digit}; blank and junk are illegal.
   function automatic logic [4:0] f_Decode(input logic [6:0] seg);
      logic [4:0] res;
      unique case (seg)
         7'b1000000: res = {1'b1, 4'd0};
         7'b1111001: res = {1'b1, 4'd1};
         7'b0100100: res = {1'b1, 4'd2};
         7'b0110000: res = {1'b1, 4'd3};
         7'b0011001: res = {1'b1, 4'd4};
         7'b0010010: res = {1'b1, 4'd5};
         7'b0000010: res = {1'b1, 4'd6};
         7'b1111000: res = {1'b1, 4'd7};
         7'b0000000: res = {1'b1, 4'd8};
         7'b0010000: res = {1'b1, 4'd9};
         default:    res = 5'd0;
      endcase
      return res;
   endfunction

   assign w_Input = {i_Segment1, i_Segment2};
   assign w_Same  = (w_Input == r_Sample);
   assign w_Go    = (r_State == COMPARE) && (w_Next == COMMIT);

   assign {w_Tens_Ok, w_Tens} = f_Decode(r_Sample[13:7]);
   assign {w_Ones_Ok, w_Ones} = f_Decode(r_Sample[6:0]);
   assign w_Score = 7'(w_Tens) * 7'd10 + 7'(w_Ones);

   // Sample register and saturating stability counter.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_Sample <= '0;
         r_Count  <= '0;
      end else begin
         r_Sample <= w_Input;
         if (!w_Same)
            r_Count <= '0;
         else if (r_Count != LP_MAX)
            r_Count <= r_Count + 8'd1;
      end
   end

   // State register.
   always_ff @(posedge i_Clk) begin
      if (i_Reset)
         r_State <= SETTLE;
      else
         r_State <= w_Next;
   end

   // Next-state logic.
   always_comb begin
      w_Next = r_State;
      unique case (r_State)
         SETTLE: begin
            if (w_Same && (r_Count == LP_LAST))
               w_Next = COMPARE;
         end
         COMPARE: begin
            if (r_Has_Commit && (r_Sample == r_Committed))
               w_Next = HOLD;
            else
               w_Next = COMMIT;
         end
         COMMIT: w_Next = HOLD;
         HOLD: begin
            if (!w_Same)
               w_Next = SETTLE;
         end
         default: w_Next = SETTLE;
      endcase
   end

   // Outputs land on the edge entering COMMIT so they are
   // visible for exactly the COMMIT cycle onwards.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_Committed  <= '0;
         r_Has_Commit <= 1'b0;
         r_Score      <= '0;
         r_Valid      <= 1'b0;
         r_Update     <= 1'b0;
         r_Error      <= 1'b0;
         r_Err_Cnt    <= '0;
      end else begin
         r_Update <= 1'b0;
         if (w_Go) begin
            r_Committed  <= r_Sample;
            r_Has_Commit <= 1'b1;
            if (w_Tens_Ok && w_Ones_Ok) begin
               r_Score  <= w_Score;
               r_Valid  <= 1'b1;
               r_Error  <= 1'b0;
               r_Update <= 1'b1;
            end else begin
               r_Valid <= 1'b0;
               r_Error <= 1'b1;
               if (r_Err_Cnt != 8'hFF)
                  r_Err_Cnt <= r_Err_Cnt + 8'd1;
            end
         end
      end
   end

   assign o_Score        = r_Score;
   assign o_Score_Valid  = r_Valid;
   assign o_Score_Update = r_Update;
   assign o_Error        = r_Error;
   assign o_Error_Count  = r_Err_Cnt;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Bench for seven_segment_decoder: directed plan steps plus random
// pairs checked against a digit-table model.
module tb_seven_segment_decoder;

   localparam int SC = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] s1;
   logic [6:0] s2;
   logic [6:0] score;
   logic       valid;
   logic       upd;
   logic       err;
   logic [7:0] ecnt;

   seven_segment_decoder #(.STABLE_CYCLES(SC)) dut (
      .i_Clk          (clk),
      .i_Reset        (rst),
      .i_Segment1     (s1),
      .i_Segment2     (s2),
      .o_Score        (score),
      .o_Score_Valid  (valid),
      .o_Score_Update (upd),
      .o_Error        (err),
      .o_Error_Count  (ecnt)
   );

   always #5 clk = ~clk;

   logic [6:0] pat [0:9] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   int n_checks = 0;
   int n_pass   = 0;

   int          m_score;
   int          m_valid;
   int          m_err;
   int          m_cnt;
   logic [13:0] m_cpair;
   bit          m_cflag;
   int          exp_pulse;
   logic [13:0] prev;

   function automatic int decode(input logic [6:0] seg);
      for (int i = 0; i < 10; i++)
         if (pat[i] == seg) return i;
      return -1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_score = 0; m_valid = 0; m_err = 0; m_cnt = 0;
      m_cpair = '0; m_cflag = 0;
   endtask

   task automatic model_commit(input logic [6:0] t, input logic [6:0] o);
      int dt, d_o;
      exp_pulse = 0;
      if (m_cflag && m_cpair == {t, o}) return;
      dt  = decode(t);
      d_o = decode(o);
      if (dt >= 0 && d_o >= 0) begin
         m_score = dt * 10 + d_o;
         m_valid = 1; m_err = 0; exp_pulse = 1;
      end else begin
         m_valid = 0; m_err = 1;
         if (m_cnt < 255) m_cnt++;
      end
      m_cpair = {t, o};
      m_cflag = 1;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".score"}, 32'(score), m_score);
      check({tag, ".valid"}, 32'(valid), m_valid);
      check({tag, ".error"}, 32'(err),   m_err);
      check({tag, ".ecnt"},  32'(ecnt),  m_cnt);
   endtask

   // Drive a pair for n edges, counting update pulses seen.
   task automatic apply(input logic [6:0] t, input logic [6:0] o,
                        input int n, input string tag);
      int pulses = 0;
      s1 = t; s2 = o; prev = {t, o};
      repeat (n) begin
         @(posedge clk); #1;
         if (upd === 1'b1) pulses++;
      end
      if (n >= SC + 2) model_commit(t, o);
      else exp_pulse = 0;
      check({tag, ".pulses"}, pulses, exp_pulse);
      check_all(tag);
   endtask

   initial begin
      int e;
      logic [6:0] t, o;
      model_reset();
      exp_pulse = 0;
      rst = 1'b1; s1 = 7'h7F; s2 = 7'h7F; prev = '1;
      repeat (2) @(posedge clk);
      #1;
      check("rst.upd", 32'(upd), 0);
      check_all("rst");
      rst = 1'b0;

      apply(pat[0], pat[9], 10, "s09");
      apply(pat[9], pat[9], 10, "s99");
      apply(pat[3], pat[4], 10, "s34");
      apply(7'h7F, pat[1], 10, "blank1");
      apply(pat[1], pat[2], 10, "s12");
      apply(pat[4], pat[0], 10, "s40");
      apply(pat[4], pat[1], 2, "glitch41");
      apply(pat[4], pat[0], 10, "back40");
      apply(pat[5], pat[7], 10, "s57");

      rst = 1'b1;
      @(posedge clk); #1;
      model_reset();
      check("rst57.upd", 32'(upd), 0);
      check_all("rst57");
      rst = 1'b0;
      e = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (upd === 1'b1) begin e = i; break; end
      end
      check("rst57.latency", e, SC + 2);
      model_commit(pat[5], pat[7]);
      check_all("recommit57");
      repeat (2) @(posedge clk);
      #1;

      for (int k = 0; k < 60; k++) begin
         do begin
            t = ($urandom_range(0, 4) == 0) ? 7'($urandom)
                                            : pat[$urandom_range(0, 9)];
            o = ($urandom_range(0, 4) == 0) ? 7'($urandom)
                                            : pat[$urandom_range(0, 9)];
         end while ({t, o} == prev);
         if ($urandom_range(0, 3) == 0)
            apply(t, o, $urandom_range(1, SC - 1), "rnd_glitch");
         else
            apply(t, o, 8, "rnd");
      end

      for (int k = 0; k < 300; k++) begin
         t = 7'h7F;
         o = (k % 2 == 0) ? 7'h00 : 7'h7F;
         if ({t, o} == prev) o = ~o;
         apply(t, o, 8, "sat");
      end
      check("sat.final", 32'(ecnt), 255);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
